// File: rtl/exec_sequencer_if.sv
// Control/observation bundle between the execution sequencer and the datapath/debug side.
interface exec_sequencer_if;
  logic        Run;
  logic        Step;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        pc_write;
  logic        commit_en;
  logic [1:0]  state;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] instr_count;

  modport master (
    output Run, Step, bp_en, bp_addr, pc_out, instruction,
    input  pc_write, commit_en, state, halted, halt_cause, instr_count
  );

  modport slave (
    input  Run, Step, bp_en, bp_addr, pc_out, instruction,
    output pc_write, commit_en, state, halted, halt_cause, instr_count
  );
endinterface

// File: rtl/exec_sequencer.sv
// Run/step/halt controller: decides per cycle whether the current instruction commits,
// with breakpoint, halt-instruction and retired-count watchdog stops.
module exec_sequencer #(
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C,
  parameter logic [31:0] MAX_INSTR  = 32'h0000_0000
) (
  input  logic            CLOCK_50,
  input  logic            Reset_n,
  exec_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [1:0]  CAUSE_NONE = 2'd0;
  localparam logic [1:0]  CAUSE_BP   = 2'd1;
  localparam logic [1:0]  CAUSE_HI   = 2'd2;
  localparam logic [1:0]  CAUSE_WD   = 2'd3;
  localparam logic [31:0] COUNT_MAX  = 32'hFFFF_FFFF;
  localparam logic        WD_EN      = (MAX_INSTR != 32'd0);

  state_t      r_state;
  logic [1:0]  r_cause;
  logic [31:0] r_count;
  logic        r_bp_skip;
  logic        r_step_q;

  logic w_step_rise;
  logic w_bp_hit;
  logic w_hi_hit;
  logic w_wd_hit;
  logic w_active;
  logic w_commit;

  // Stop conditions and the Mealy commit qualifier
  assign w_step_rise = bus.Step & ~r_step_q;
  assign w_bp_hit    = bus.bp_en & (bus.pc_out == bus.bp_addr) & ~r_bp_skip;
  assign w_hi_hit    = (bus.instruction == HALT_INSTR);
  assign w_wd_hit    = WD_EN & (r_count == MAX_INSTR);
  assign w_active    = ((r_state == S_RUN) & bus.Run) | (r_state == S_STEP);
  assign w_commit    = w_active & ~w_hi_hit & ~w_bp_hit & ~w_wd_hit;

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_cause   <= CAUSE_NONE;
      r_count   <= 32'd0;
      r_bp_skip <= 1'b0;
      r_step_q  <= 1'b0;
    end else begin
      r_step_q <= bus.Step;

      if (w_commit) begin
        if (r_count != COUNT_MAX) r_count <= r_count + 32'd1;
        r_bp_skip <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.Run)          r_state <= S_RUN;
          else if (w_step_rise) r_state <= S_STEP;
        end
        S_RUN, S_STEP: begin
          if ((r_state == S_RUN) && !bus.Run) begin
            r_state <= S_IDLE;
          end else if (w_hi_hit) begin
            r_state <= S_HALT;
            r_cause <= CAUSE_HI;
          end else if (w_bp_hit) begin
            r_state <= S_HALT;
            r_cause <= CAUSE_BP;
          end else if (w_wd_hit) begin
            r_state <= S_HALT;
            r_cause <= CAUSE_WD;
          end else if (r_state == S_STEP) begin
            r_state <= S_IDLE;
          end
        end
        S_HALT: begin
          // Only a breakpoint halt can be resumed; skip arms so the same PC commits once
          if ((r_cause == CAUSE_BP) && (bus.Run || w_step_rise)) begin
            r_state   <= bus.Run ? S_RUN : S_STEP;
            r_bp_skip <= 1'b1;
            r_cause   <= CAUSE_NONE;
          end
        end
      endcase
    end
  end

  assign bus.pc_write    = w_commit;
  assign bus.commit_en   = w_commit;
  assign bus.state       = r_state;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.halt_cause  = r_cause;
  assign bus.instr_count = r_count;
endmodule
